// File: rtl/inv_permutation_decoder.sv
// inv_permutation_decoder: undoes the encoder's 5x5 bit-plane permutation.
// Frame of LINES 25-bit lines; each line gets ROUNDS inverse passes, one per clock.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   start     in   begins a frame (sampled in IDLE only)
//   in_data   in   [24:0] encoded line
//   in_valid  in   in_data valid
//   in_ready  out  block can accept a line (LOAD)
//   out_data  out  [24:0] decoded line
//   out_valid out  out_data valid (EMIT)
//   out_ready in   sink accepts out_data
//   line_idx  out  [5:0] index of the line currently held
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse at end of frame
//   out_parity out [4:0] column parity of out_data (only with INV_PERM_PARITY_EN)
//
// Optional feature macro: INV_PERM_PARITY_EN

module inv_permutation_decoder #(
    parameter int LINES  = 64,
    parameter int ROUNDS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [24:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  line_idx,
    output logic        busy,
`ifdef INV_PERM_PARITY_EN
    output logic [4:0]  out_parity,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PERM,
        EMIT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] buf_q, buf_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [24:0] pass;

    // One inverse pass: D(x,y) = E(y, (2x+3y) mod 5), bit (x,y) at x+5y.
    // Pure rewire; the loops only enumerate wires.
    function automatic logic [24:0] inv_pass(input logic [24:0] e);
        logic [24:0] d;
        d = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                d[x + 5*y] = e[y + 5*((2*x + 3*y) % 5)];
            end
        end
        return d;
    endfunction

    assign pass = inv_pass(buf_q);

`ifdef INV_PERM_PARITY_EN
    logic [4:0] par_q, par_d;

    function automatic logic [4:0] col_parity(input logic [24:0] d);
        logic [4:0] p;
        p = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                p[x] = p[x] ^ d[x + 5*y];
            end
        end
        return p;
    endfunction

    // Tracks the buffer through every pass so it is ready with out_valid.
    always_comb begin
        par_d = par_q;
        if (state_q == PERM) begin
            par_d = col_parity(pass);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign out_parity = par_q;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    buf_d   = in_data;
                    rnd_d   = '0;
                    state_d = PERM;
                end
            end
            PERM: begin
                buf_d = pass;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'(ROUNDS - 1)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == 6'(LINES - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == EMIT);
    assign out_data  = buf_q;
    assign line_idx  = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_inv_permutation_decoder.sv
// Bench for inv_permutation_decoder: two instances (64 lines x 1 round,
// 1 line x 2 rounds), random stimulus, queue scoreboard against a plane model.

module tb_inv_permutation_decoder;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp,
                     $time);
        end
    endtask

    // Reference: decode by treating the line as a 5x5 array and
    // applying D[x][y] = E[y][(2x+3y) mod 5] r times.
    function automatic logic [24:0] model(input logic [24:0] e, input int r);
        logic p[5][5];
        logic q[5][5];
        logic [24:0] v;
        v = e;
        for (int k = 0; k < r; k++) begin
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    p[x][y] = v[x + 5*y];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    q[x][y] = p[y][(2*x + 3*y) % 5];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    v[x + 5*y] = q[x][y];
        end
        return v;
    endfunction

    function automatic logic [4:0] par_of(input logic [24:0] d);
        logic [4:0] p;
        p = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                p[x] = p[x] ^ d[x + 5*y];
        return p;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int L = (g == 0) ? 64 : 1;
        localparam int R = (g == 0) ? 1 : 2;

        logic        rst;
        logic        start;
        logic [24:0] in_data;
        logic        in_valid;
        logic        in_ready;
        logic [24:0] out_data;
        logic        out_valid;
        logic        out_ready;
        logic [5:0]  line_idx;
        logic        busy;
        logic        done;
`ifdef INV_PERM_PARITY_EN
        logic [4:0]  out_parity;
`endif

        inv_permutation_decoder #(.LINES(L), .ROUNDS(R)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .in_data   (in_data),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .line_idx  (line_idx),
            .busy      (busy),
`ifdef INV_PERM_PARITY_EN
            .out_parity(out_parity),
`endif
            .done      (done)
        );

        logic [24:0] exp_q[$];
        logic [24:0] held;
        int exp_idx = 0;
        int acc_cyc = 0;
        int ndone = 0;
        int nout = 0;
        bit stalled = 0;
        bit hold_mode = 0;
        bit exp_done = 0;
        bit post = 0;
        bit fin = 0;

        // Monitor: pops the scoreboard on each new output, drives out_ready.
        initial begin
            logic [24:0] e;
            forever begin
                @(negedge clk);
                if (rst) begin
                    stalled  = 0;
                    exp_done = 0;
                    post     = 0;
                end else begin
                    if (post) begin
                        chk("busy_after_done", {31'd0, busy}, 0);
                        post = 0;
                    end
                    if (exp_done) begin
                        chk("done_pulse", {31'd0, done}, 1);
                        exp_done = 0;
                        ndone++;
                        post = 1;
                    end else if (done) begin
                        chk("spurious_done", {31'd0, done}, 0);
                    end
                    if (out_valid) begin
                        if (stalled) begin
                            chk("stall_stable", {7'd0, out_data}, {7'd0, held});
                        end else if (exp_q.size() == 0) begin
                            chk("unexpected_out", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("data", {7'd0, out_data}, {7'd0, e});
`ifdef INV_PERM_PARITY_EN
                            chk("parity", {27'd0, out_parity}, {27'd0, par_of(e)});
`endif
                            chk("line_idx", {26'd0, line_idx}, exp_idx);
                            chk("latency", cyc - acc_cyc, R);
                            held = out_data;
                        end
                        if (hold_mode && line_idx == 6'd10)
                            out_ready = 1'b0;
                        else
                            out_ready = ($urandom_range(0, 2) != 0);
                        stalled = !out_ready;
                        if (out_ready) begin
                            if (exp_idx == L - 1) exp_done = 1;
                            exp_idx++;
                            nout++;
                        end
                    end else begin
                        out_ready = 1'($urandom_range(0, 1));
                        stalled   = 0;
                    end
                end
            end
        end

        task automatic drive_frame(input int n);
            logic [24:0] dir[4];
            logic [24:0] d;
            int t;
            dir[0] = 25'h0000002;
            dir[1] = 25'h0000020;
            dir[2] = 25'h0000001;
            dir[3] = 25'h1FFFFFF;
            exp_idx = 0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < n; i++) begin
                d = (i < 4) ? dir[i] : 25'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                in_valid = 1'b1;
                in_data  = d;
                t = 0;
                while (!in_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (!in_ready) begin
                    chk("in_ready_timeout", 0, 1);
                end else begin
                    exp_q.push_back(model(d, R));
                    acc_cyc = cyc + 1;
                    @(negedge clk);
                end
                in_valid = 1'b0;
                in_data  = '0;
            end
        endtask

        task automatic wait_done(input int target);
            int t;
            t = 0;
            while (ndone < target && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (ndone < target) chk("frame_timeout", ndone, target);
            repeat (2) @(negedge clk);
        endtask

        initial begin
            int t;
            rst       = 1'b1;
            start     = 1'b0;
            in_valid  = 1'b0;
            in_data   = '0;
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_data", {7'd0, out_data}, 0);
            chk("rst_ctl", {22'd0, in_ready, out_valid, line_idx, busy, done}, 0);
            #2 rst = 1'b0;

            drive_frame(L);
            wait_done(1);

            if (g == 0) begin
                // Abort a frame while line 10 is stalled in EMIT.
                hold_mode = 1;
                drive_frame(11);
                t = 0;
                while (!(out_valid && line_idx == 6'd10) && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                chk("hold_line10", {26'd0, line_idx}, 10);
                #2 rst = 1'b1;
                #1;
                chk("abort_data", {7'd0, out_data}, 0);
                chk("abort_ctl", {22'd0, in_ready, out_valid, line_idx, busy, done}, 0);
`ifdef INV_PERM_PARITY_EN
                chk("abort_parity", {27'd0, out_parity}, 0);
`endif
                exp_q.delete();
                exp_idx   = 0;
                hold_mode = 0;
                @(negedge clk);
                chk("abort_busy", {31'd0, busy}, 0);
                #2 rst = 1'b0;
                drive_frame(L);
                wait_done(2);
            end

            chk("done_count", ndone, (g == 0) ? 2 : 1);
            chk("out_count", nout, (g == 0) ? 2 * L + 10 : L);
            chk("queue_empty", exp_q.size(), 0);
            fin = 1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(inst[0].fin && inst[1].fin) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (!(inst[0].fin && inst[1].fin)) chk("global_timeout", 0, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_permutation_decoder.md
Name: inv_permutation_decoder

Overview:
- Decoder-side counterpart of the matrix permutation encoder: it undoes the encoder's permutation.
- Accepts a frame of LINES encoded 25-bit lines over a valid/ready stream.
- Each line is treated as a 5x5 bit plane. The block applies the inverse plane permutation ROUNDS times and emits the recovered line over a second valid/ready stream.
- Sits between the encoded-line source (file reader / upstream stage) and the plaintext sink, under control of a top-level start/done handshake.

Parameters:
- LINES, 64, lines per frame; legal range 1..64.
- ROUNDS, 1, inverse-permutation passes per line, one per clock; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins a frame; sampled in IDLE only
- in_data  input  25  encoded line
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a line
- out_data  output  25  decoded line
- out_valid  output  1  out_data valid
- out_ready  input  1  sink accepts out_data
- line_idx  output  6  index of line currently held, 0..LINES-1
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of frame

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE, line buffer 0, line and round counters 0.
- Reset mid-frame aborts immediately. No partial output is held, and no done pulse is produced.
- Bit mapping: plane bit (x,y), with x,y in 0..4, is at index x+5y.
- One inverse pass: D(x,y) = E(y, (2x+3y) mod 5), where E is the line before the pass and D the line after it. The map is a pure bit rewire with no arithmetic carry.
- States are IDLE, LOAD, PERM, EMIT, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 clears line_idx and moves to LOAD.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, in_data is captured into the buffer, the round counter clears, and the state moves to PERM.
  - in_valid in any other state is not consumed.
- PERM:
  - Each cycle applies one pass to the buffer and increments the round counter.
  - After ROUNDS passes, moves to EMIT.
  - in_ready=0.
- EMIT:
  - out_valid=1, out_data=buffer.
  - out_data and out_valid hold stable until out_ready=1.
  - On the handshake: if line_idx==LINES-1, go to DONE; otherwise line_idx+1 and go to LOAD.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the following cycle.
- Latency: out_valid rises right after the ROUNDS-th rising edge following the accepting edge.
- Throughput: at most one line per ROUNDS+2 cycles.
- Backpressure: out_ready low stalls indefinitely. in_ready stays 0 until the stalled output is taken.
- line_idx does not wrap: the frame ends at LINES-1. A new start is needed for the next frame.
- Simultaneous start and DONE: start is ignored because it is sampled in IDLE only.

Optional Feature:
- Macro: INV_PERM_PARITY_EN
- Defined:
  - Adds output out_parity[4:0], where out_parity[x] = XOR over y of out_data(x,y).
  - out_parity is registered alongside out_data, valid with out_valid, and 0 at reset.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
1. ROUNDS=1, LINES=1: start; in_data=25'h0000002 -> out_data=25'h0000040, line_idx=0, done pulses one cycle after the out handshake.
2. ROUNDS=1: in_data=25'h0000020 -> out_data=25'h0000008. in_data=25'h0000001 -> out_data=25'h0000001 (fixed point).
3. ROUNDS=2: in_data=25'h0000002 -> out_data=25'h0000200, out_valid exactly 2 edges after accept.
4. LINES=64, random in_data, random in_valid/out_ready gaps -> 64 outputs matching the model, in order, line_idx 0..63; done once; out_data stable during stalls.
5. rst asserted while in EMIT with line_idx=10 -> all outputs 0 asynchronously, state IDLE; the next start restarts at line_idx=0.
6. INV_PERM_PARITY_EN defined, in_data=25'h1FFFFFF -> out_data=25'h1FFFFFF, out_parity=5'h1F.
